// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one SLICE-bit ripple segment per register stage,
// with the carry and the still-pending operand bits registered between stages.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;

  if ((WIDTH < 2) || (SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH=%0d must be >= 2 and a multiple of SLICE=%0d", WIDTH, SLICE);
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Subtraction is A + ~B + ~borrow_in.
  assign w_b_eff = bus.op_sub ? ~bus.b : bus.b;
  assign w_c0    = bus.op_sub ^ bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO   = k * SLICE;
    localparam int unsigned PEND = WIDTH - (k + 1) * SLICE;

    logic [SLICE-1:0]    w_a_sl;
    logic [SLICE-1:0]    w_b_sl;
    logic                w_c_in;
    logic                w_v_in;
    logic [SLICE:0]      w_add;
    logic [LO+SLICE-1:0] w_res;
    logic [LO+SLICE-1:0] r_s;
    logic                r_v;

    if (k == 0) begin : g_first
      assign w_a_sl = bus.a[SLICE-1:0];
      assign w_b_sl = w_b_eff[SLICE-1:0];
      assign w_c_in = w_c0;
      assign w_v_in = bus.in_valid;
      assign w_res  = w_add[SLICE-1:0];
    end else begin : g_next
      assign w_a_sl = g_stage[k-1].g_pend.r_a[SLICE-1:0];
      assign w_b_sl = g_stage[k-1].g_pend.r_b[SLICE-1:0];
      assign w_c_in = g_stage[k-1].g_pend.r_c;
      assign w_v_in = g_stage[k-1].r_v;
      assign w_res  = {w_add[SLICE-1:0], g_stage[k-1].r_s};
    end

    assign w_add = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(w_c_in);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_s <= w_res;
      end
    end

    // Upper operand bits not yet resolved ride along with the op.
    if (k < LAST) begin : g_pend
      logic [PEND-1:0] w_a_up;
      logic [PEND-1:0] w_b_up;
      logic [PEND-1:0] r_a;
      logic [PEND-1:0] r_b;
      logic            r_c;

      if (k == 0) begin : g_src_in
        assign w_a_up = bus.a[WIDTH-1:SLICE];
        assign w_b_up = w_b_eff[WIDTH-1:SLICE];
      end else begin : g_src_prev
        assign w_a_up = g_stage[k-1].g_pend.r_a[PEND+SLICE-1:SLICE];
        assign w_b_up = g_stage[k-1].g_pend.r_b[PEND+SLICE-1:SLICE];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_c <= 1'b0;
        end else if (w_adv) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
          r_c <= w_add[SLICE];
        end
      end
    end
  end

  // Flags come from the top segment, registered alongside the final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_adv) begin
      r_carry <= g_stage[LAST].w_add[SLICE];
      r_ovf   <= (g_stage[LAST].w_a_sl[SLICE-1] == g_stage[LAST].w_b_sl[SLICE-1]) &
                 (g_stage[LAST].w_add[SLICE-1] != g_stage[LAST].w_a_sl[SLICE-1]);
      r_zero  <= (g_stage[LAST].w_res == '0);
      r_neg   <= g_stage[LAST].w_add[SLICE-1];
    end
  end

  assign w_adv         = ~g_stage[LAST].r_v | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = g_stage[LAST].r_v;
  assign bus.sum       = g_stage[LAST].r_s;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_neg;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 8/4 directed table, stream stall, mid-flight reset,
// 16/16 single-stage boundary and a 32/8 randomised scoreboard run.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(8))  x8 ();
  pipelined_addsub_if #(.WIDTH(16)) x16 ();
  pipelined_addsub_if #(.WIDTH(32)) x32 ();

  pipelined_addsub #(.WIDTH(8),  .SLICE(4))  u_d8  (.clk(clk), .rst(rst), .bus(x8));
  pipelined_addsub #(.WIDTH(16), .SLICE(16)) u_d16 (.clk(clk), .rst(rst), .bus(x16));
  pipelined_addsub #(.WIDTH(32), .SLICE(8))  u_d32 (.clk(clk), .rst(rst), .bus(x32));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       neg;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin, input logic sub);
    longint ua, ub, uc, ur, sa, sb, sr, lim;
    logic [63:0] bits;
    logic c, o;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    uc = cin ? 64'sd1 : 64'sd0;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (sub) begin
      ur = ua - ub - uc;
      sr = sa - sb - uc;
      c  = (ur >= 0);
    end else begin
      ur = ua + ub + uc;
      sr = sa + sb + uc;
      c  = (ur >= (longint'(1) << w));
    end
    lim  = longint'(1) << (w - 1);
    o    = (sr >= lim) || (sr < -lim);
    bits = 64'(ur) & ((64'd1 << w) - 64'd1);
    return {o, c, bits[31:0]};
  endfunction

  task automatic run8(input vec_t v, input int idx);
    int lat;
    x8.a = v.a; x8.b = v.b; x8.cin = v.cin; x8.op_sub = v.sub; x8.in_valid = 1'b1;
    check($sformatf("v%0d_in_ready", idx), x8.in_ready, 1);
    @(posedge clk); #1;
    x8.in_valid = 1'b0;
    lat = 1;
    while (!x8.out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, 2);
    check($sformatf("v%0d_sum", idx), x8.sum, v.sum);
    check($sformatf("v%0d_carry", idx), x8.carry, v.carry);
    check($sformatf("v%0d_ovf", idx), x8.overflow, v.ovf);
    check($sformatf("v%0d_zero", idx), x8.zero, v.zero);
    check($sformatf("v%0d_neg", idx), x8.negative, v.neg);
  endtask

  vec_t        vecs[10];
  logic [33:0] q8[$];
  logic [33:0] q32[$];

  initial begin
    int sent, got, cyc, ni, lat, any_v;
    logic acc, stall_prev;
    logic [7:0] held_sum;
    logic [33:0] m;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    x8.in_valid = 0;  x8.a = '0;  x8.b = '0;  x8.cin = 0;  x8.op_sub = 0;  x8.out_ready = 1;
    x16.in_valid = 0; x16.a = '0; x16.b = '0; x16.cin = 0; x16.op_sub = 0; x16.out_ready = 1;
    x32.in_valid = 0; x32.a = '0; x32.b = '0; x32.cin = 0; x32.op_sub = 0; x32.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst8_out", {x8.out_valid, x8.sum, x8.carry, x8.overflow, x8.zero, x8.negative}, 0);
    check("rst8_in_ready", x8.in_ready, 1);
    check("rst16_out", {x16.out_valid, x16.sum, x16.carry, x16.overflow, x16.zero, x16.negative}, 0);
    check("rst32_out", {x32.out_valid, x32.sum, x32.carry, x32.overflow, x32.zero, x32.negative}, 0);
    check("rst32_in_ready", x32.in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run8(vecs[i], i);
    @(posedge clk); #1;

    // Six back-to-back ops with a three-cycle output stall in the middle.
    sent = 0; got = 0; cyc = 0; ni = 0; acc = 1'b1; stall_prev = 1'b0; held_sum = '0;
    while (got < 6 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (ni < 6) begin
          x8.a = 8'(ni * 37 + 5); x8.b = 8'(ni * 91 + 200);
          x8.cin = ni[0]; x8.op_sub = ni[1]; x8.in_valid = 1'b1;
        end else x8.in_valid = 1'b0;
      end
      x8.out_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      acc = x8.in_valid && x8.in_ready;
      if (acc) begin
        q8.push_back(model(8, {24'd0, x8.a}, {24'd0, x8.b}, x8.cin, x8.op_sub));
        ni++; sent++;
      end
      if (x8.out_valid && !x8.out_ready) begin
        check("stall_in_ready", x8.in_ready, 0);
        if (stall_prev) check("stall_sum_stable", x8.sum, held_sum);
        held_sum = x8.sum;
        stall_prev = 1'b1;
      end else stall_prev = 1'b0;
      if (x8.out_valid && x8.out_ready) begin
        check("stream_pending", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          m = q8.pop_front();
          check($sformatf("stream%0d_result", got),
                {x8.overflow, x8.carry, x8.sum}, {m[33], m[32], m[7:0]});
        end
        got++;
      end
    end
    check("stream_count", got, 6);
    check("stream_sent", sent, 6);
    x8.in_valid = 1'b0; x8.out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset with two ops in flight: both must vanish.
    x8.out_ready = 1'b0;
    x8.a = 8'h11; x8.b = 8'h22; x8.cin = 0; x8.op_sub = 0; x8.in_valid = 1'b1;
    @(posedge clk); #1;
    x8.a = 8'h33; x8.b = 8'h44;
    @(posedge clk); #1;
    x8.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", x8.out_valid, 0);
    check("midrst_in_ready", x8.in_ready, 1);
    x8.out_ready = 1'b1;
    any_v = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (x8.out_valid) any_v++;
    end
    check("midrst_no_ghost", any_v, 0);
    run8('{8'h40, 8'h3F, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1}, 90);

    // Single-stage boundary: latency 1.
    x16.a = 16'h8000; x16.b = 16'h0001; x16.cin = 1; x16.op_sub = 1; x16.in_valid = 1'b1;
    @(posedge clk); #1;
    x16.in_valid = 1'b0;
    check("w16_sub_valid_1clk", x16.out_valid, 1);
    check("w16_sub_sum", x16.sum, 16'h7FFE);
    check("w16_sub_flags", {x16.carry, x16.overflow, x16.zero, x16.negative}, 4'b1100);
    x16.a = 16'hFFFF; x16.b = 16'h0001; x16.cin = 0; x16.op_sub = 0; x16.in_valid = 1'b1;
    @(posedge clk); #1;
    x16.in_valid = 1'b0;
    check("w16_add_valid_1clk", x16.out_valid, 1);
    check("w16_add_sum", x16.sum, 16'h0000);
    check("w16_add_flags", {x16.carry, x16.overflow, x16.zero, x16.negative}, 4'b1010);

    // 32/8: first op latency 4, then random traffic with bubbles and stalls.
    x32.a = 32'hFFFF_FFFF; x32.b = 32'h1; x32.cin = 0; x32.op_sub = 0; x32.in_valid = 1'b1;
    @(posedge clk); #1;
    x32.in_valid = 1'b0;
    lat = 1;
    while (!x32.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w32_latency", lat, 4);
    check("w32_wrap", {x32.carry, x32.zero, x32.sum}, {1'b1, 1'b1, 32'h0});
    @(posedge clk); #1;

    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    while (got < 1500 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) x32.in_valid = 1'b0;
      if (!x32.in_valid && sent < 1500 && $urandom_range(3) != 0) begin
        x32.a = $urandom; x32.b = $urandom;
        x32.cin = 1'($urandom_range(1)); x32.op_sub = 1'($urandom_range(1));
        x32.in_valid = 1'b1;
      end
      x32.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = x32.in_valid && x32.in_ready;
      if (acc) begin
        q32.push_back(model(32, x32.a, x32.b, x32.cin, x32.op_sub));
        sent++;
      end
      if (x32.out_valid && x32.out_ready) begin
        check("rand_pending", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          m = q32.pop_front();
          check($sformatf("rand%0d_result", got),
                {x32.overflow, x32.carry, x32.zero, x32.negative, x32.sum},
                {m[33], m[32], m[31:0] == 32'd0, m[31], m[31:0]});
        end
        got++;
      end
    end
    check("rand_count", got, 1500);
    check("rand_queue_drained", q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
